ulpb_tx_queue: RTL and testbench
================================

# ulpb_tx_queue

Transmit-side message queue placed directly upstream of the ulpb bus node. It buffers (address, data) messages from the local host, presents them one at a time on the node's `ADDR_IN`/`DATA_IN`/`REQ_TX`/`ACK_TX` handshake, and watches the node's `ACK_RECEIVED` for the receiver's acknowledge. A message that is not acknowledged within a timeout is retransmitted up to a bounded number of times, then dropped and reported as failed.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: message address width; must match the node.
- `DATA_WIDTH`, 32: message payload width; must match the node.
- `DEPTH`, 4: number of queue entries; a power of 2, at least 2.
- `TIMEOUT`, 256: cycles to wait for `ACK_RECEIVED` after `ACK_TX`; at least 2.
- `MAX_RETRY`, 3: retransmissions allowed after the first attempt.

Ports:
- `CLK`  in  1  the only clock; all state changes on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `WR_VALID`  in  1  host offers a message.
- `WR_READY`  out  1  queue can accept; `WR_READY = (COUNT != DEPTH)`.
- `WR_ADDR`  in  ADDR_WIDTH  destination address of the offered message.
- `WR_DATA`  in  DATA_WIDTH  payload of the offered message.
- `TX_ADDR`  out  ADDR_WIDTH  head entry address, to node `ADDR_IN`.
- `TX_DATA`  out  DATA_WIDTH  head entry payload, to node `DATA_IN`.
- `REQ_TX`  out  1  registered transmit request, to node.
- `ACK_TX`  in  1  node has latched `TX_ADDR`/`TX_DATA` and won arbitration.
- `ACK_RECEIVED`  in  1  node level flag: receiver acknowledged the last transaction.
- `TX_DONE`  out  1  one-cycle pulse when the head message is acknowledged and popped.
- `TX_FAIL`  out  1  one-cycle pulse when the head message is dropped after its retries are exhausted.
- `COUNT`  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer with write pointer, read pointer and `COUNT`.
  - Push happens when `WR_VALID & WR_READY`.
  - Pop happens only on `TX_DONE` or `TX_FAIL`.
  - A push and a pop in the same cycle leave `COUNT` unchanged. Pointers wrap modulo `DEPTH`.
  - There is no bypass. When full, `WR_READY` stays 0 even in the cycle a pop occurs.
- `TX_ADDR`/`TX_DATA` always show the entry at the read pointer. Their value is don't-care when the queue is empty.
- Internal registers: `ack_rcv_d`, a one-cycle delay of `ACK_RECEIVED`; `timer`; `retry` (0..MAX_RETRY).
- `ack_rise = ACK_RECEIVED & ~ack_rcv_d`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when `COUNT != 0` and `ACK_TX == 0`. `REQ_TX` is set to 1 on that edge.
  - REQ: hold `REQ_TX = 1` and keep the head stable. When `ACK_TX == 1`: clear `REQ_TX`, load `timer = TIMEOUT-1`, go to WAIT.
  - WAIT, conditions checked in priority order:
    - `ack_rise`: pop, pulse `TX_DONE`, set `retry = 0`, go to IDLE.
    - else `timer == 0` and `retry == MAX_RETRY`: pop, pulse `TX_FAIL`, set `retry = 0`, go to IDLE.
    - else `timer == 0`: increment `retry`, go to IDLE. The head is kept and re-requested.
    - else decrement `timer`.
- `ack_rise` seen outside WAIT is ignored. A stale high `ACK_RECEIVED` from an earlier transaction therefore never completes a new one.
- Host writes are accepted in every state. They never disturb the head entry.

## Timing
- Reset values: `REQ_TX = 0`, `TX_DONE = 0`, `TX_FAIL = 0`, `COUNT = 0`, `WR_READY = 1`, FSM in IDLE, pointers 0, `retry = 0`, `timer = 0`, `ack_rcv_d = 0`. Storage contents are not reset.
- Reset asserted mid-transfer empties the queue and drops `REQ_TX` asynchronously. No `TX_DONE`/`TX_FAIL` pulse is generated.
- Request latency, with the queue empty and in IDLE: push accepted on edge N → `COUNT = 1` after N → `REQ_TX = 1` after edge N+1.
- `REQ_TX` falls on the first edge that samples `ACK_TX = 1`.
- A new `REQ_TX` is never raised while `ACK_TX` is still 1.
- Ack detection: `TX_DONE` is high for the cycle after the edge at which WAIT samples `ACK_RECEIVED = 1` with `ack_rcv_d = 0`.
- Timeout: with no ack, WAIT lasts exactly `TIMEOUT` cycles.
- If an ack arrives on the same edge as the timeout, success takes priority.
- Back-to-back messages: the next `REQ_TX` rises at the earliest 2 cycles after a pop.

## Test plan
- Single message: push addr 0xAB, data 0x12345678. `REQ_TX` rises 2 cycles later. Drive `ACK_TX` 1 → `REQ_TX` falls next edge and `TX_ADDR`/`TX_DATA` equal 0xAB/0x12345678. Raise `ACK_RECEIVED` 20 cycles later → one `TX_DONE` pulse, `COUNT` goes 1→0.
- Fill and wrap: push 6 messages at DEPTH=4 → `WR_READY` is 0 after the 4th push. Ack each message in turn → all 6 emerge in push order, and pointer wrap is exercised.
- Retry: `ACK_TX` given, `ACK_RECEIVED` held 0 → `REQ_TX` re-raised with the same head after `TIMEOUT` cycles. Ack on the 2nd attempt → `TX_DONE`, `retry` back to 0.
- Exhaustion: never acknowledge, with MAX_RETRY=3 → 4 requests, then a `TX_FAIL` pulse. The next entry is then requested.
- Stale ack: hold `ACK_RECEIVED = 1` from before `ACK_TX` through WAIT → no `TX_DONE`; the message times out and is retried.
- Reset mid-WAIT with `COUNT = 3` → `REQ_TX = 0`, `COUNT = 0`, `WR_READY = 1`, and no pulses.

Source files
------------

// File: rtl/ulpb_tx_queue.sv
// Transmit message queue in front of the ulpb node: buffers host messages, requests
// transmission of the head entry, waits for the receiver ack and retries on timeout.
module ulpb_tx_queue #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned TIMEOUT    = 256,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    WR_VALID,
   output logic                    WR_READY,
   input  logic [ADDR_WIDTH-1:0]   WR_ADDR,
   input  logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic [ADDR_WIDTH-1:0]   TX_ADDR,
   output logic [DATA_WIDTH-1:0]   TX_DATA,
   output logic                    REQ_TX,
   input  logic                    ACK_TX,
   input  logic                    ACK_RECEIVED,
   output logic                    TX_DONE,
   output logic                    TX_FAIL,
   output logic [$clog2(DEPTH):0]  COUNT
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                r_state;
   logic [TW-1:0]         r_timer;
   logic [RW-1:0]         r_retry;
   logic                  r_ack_rcv_d;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_req_tx;
   logic                  r_tx_done;
   logic                  r_tx_fail;
   logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

   logic w_wr_ready;
   logic w_push;
   logic w_ack_rise;
   logic w_pop;

   assign w_wr_ready = (r_count != CW'(DEPTH));
   assign w_push     = WR_VALID & w_wr_ready;
   assign w_ack_rise = ACK_RECEIVED & ~r_ack_rcv_d;
   assign w_pop      = (r_state == S_WAIT) &
                       (w_ack_rise | ((r_timer == '0) && (r_retry == RW'(MAX_RETRY))));

   assign WR_READY = w_wr_ready;
   assign TX_ADDR  = r_mem_addr[r_rd_ptr];
   assign TX_DATA  = r_mem_data[r_rd_ptr];
   assign REQ_TX   = r_req_tx;
   assign TX_DONE  = r_tx_done;
   assign TX_FAIL  = r_tx_fail;
   assign COUNT    = r_count;

   // Message storage; contents are don't-care until written, so no reset.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem_addr[r_wr_ptr] <= WR_ADDR;
         r_mem_data[r_wr_ptr] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Request / wait-for-ack / retry sequencer; a rising ack only counts while waiting.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_retry     <= '0;
         r_ack_rcv_d <= 1'b0;
         r_req_tx    <= 1'b0;
         r_tx_done   <= 1'b0;
         r_tx_fail   <= 1'b0;
      end else begin
         r_ack_rcv_d <= ACK_RECEIVED;
         r_tx_done   <= 1'b0;
         r_tx_fail   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if ((r_count != '0) && !ACK_TX) begin
                  r_req_tx <= 1'b1;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               if (ACK_TX) begin
                  r_req_tx <= 1'b0;
                  r_timer  <= TW'(TIMEOUT - 1);
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_ack_rise) begin
                  r_tx_done <= 1'b1;
                  r_retry   <= '0;
                  r_state   <= S_IDLE;
               end else if (r_timer == '0) begin
                  if (r_retry == RW'(MAX_RETRY)) begin
                     r_tx_fail <= 1'b1;
                     r_retry   <= '0;
                  end else begin
                     r_retry <= r_retry + RW'(1);
                  end
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: begin
               r_req_tx <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ulpb_tx_queue.sv
// Bench for ulpb_tx_queue: directed handshake sequences, a table of message plans and
// random traffic, all checked against a message-level model of the queue.
module tb_ulpb_tx_queue;

   localparam int unsigned AW        = 8;
   localparam int unsigned DW        = 32;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned TIMEOUT   = 32;
   localparam int unsigned MAX_RETRY = 3;

   logic                   clk, rst;
   logic                   wr_valid, wr_ready, req_tx, ack_tx, ack_rcv, tx_done, tx_fail;
   logic [AW-1:0]          wr_addr, tx_addr;
   logic [DW-1:0]          wr_data, tx_data;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   ulpb_tx_queue #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .TIMEOUT    (TIMEOUT),
      .MAX_RETRY  (MAX_RETRY)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .WR_VALID     (wr_valid),
      .WR_READY     (wr_ready),
      .WR_ADDR      (wr_addr),
      .WR_DATA      (wr_data),
      .TX_ADDR      (tx_addr),
      .TX_DATA      (tx_data),
      .REQ_TX       (req_tx),
      .ACK_TX       (ack_tx),
      .ACK_RECEIVED (ack_rcv),
      .TX_DONE      (tx_done),
      .TX_FAIL      (tx_fail),
      .COUNT        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Message plan: how many attempts go unacknowledged, when the ack arrives, and the outcome.
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            nfail;
      int            ackdly;
      bit            exp_done;
      int            exp_att;
   } msg_t;

   msg_t tbl [6];
   msg_t pend [$];
   msg_t mq [$];
   msg_t push_msg;
   bit   push_pend;
   bit   host_always;
   int   att, phase, ncnt, pops, max_fill;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      ack_tx   = 1'b0;
      ack_rcv  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_req(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (req_tx) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Cycles from the ACK_TX edge until REQ_TX is seen again, counting any pulses meanwhile.
   task automatic measure_retry(output int n, output int pulses);
      n = 0;
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (tx_done || tx_fail) pulses++;
         if (req_tx) break;
      end
   endtask

   function automatic msg_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int nfail, input int ackdly);
      msg_t m;
      m.addr     = a;
      m.data     = d;
      m.nfail    = nfail;
      m.ackdly   = ackdly;
      m.exp_done = (nfail <= int'(MAX_RETRY));
      m.exp_att  = m.exp_done ? nfail + 1 : int'(MAX_RETRY) + 1;
      return m;
   endfunction

   task automatic eng_init();
      pend.delete();
      mq.delete();
      push_pend = 1'b0;
      att       = 0;
      phase     = 0;
      ncnt      = 0;
      pops      = 0;
      max_fill  = 0;
   endtask

   // One clock of model + node responder + host driver.
   task automatic eng_step();
      msg_t m;
      @(negedge clk);
      if (push_pend) mq.push_back(push_msg);
      push_pend = 1'b0;
      ack_tx    = 1'b0;
      ack_rcv   = 1'b0;
      if (tx_done || tx_fail) begin
         chk("done_fail_exclusive", 64'(tx_done & tx_fail), 0);
         chk("pop_model_nonempty", 64'(mq.size() != 0), 1);
         if (mq.size() != 0) begin
            m = mq.pop_front();
            chk("outcome_done", 64'(tx_done), 64'(m.exp_done));
            chk("attempts", 64'(att), 64'(m.exp_att));
            pops++;
         end
         att   = 0;
         phase = 0;
         ncnt  = int'($urandom_range(0, 2));
      end
      chk("count", 64'(count), 64'(mq.size()));
      chk("wr_ready", 64'(wr_ready), 64'(mq.size() != int'(DEPTH)));
      if (mq.size() > max_fill) max_fill = mq.size();
      if (req_tx) begin
         chk("req_model_nonempty", 64'(mq.size() != 0), 1);
         if (mq.size() != 0) begin
            chk("head_addr", 64'(tx_addr), 64'(mq[0].addr));
            chk("head_data", 64'(tx_data), 64'(mq[0].data));
         end
      end
      case (phase)
         0: begin
            if (req_tx && mq.size() != 0) begin
               if (ncnt == 0) begin
                  ack_tx = 1'b1;
                  att++;
                  if (att > mq[0].nfail) begin
                     phase = 1;
                     ncnt  = mq[0].ackdly - 1;
                  end else begin
                     ncnt = int'($urandom_range(0, 2));
                  end
               end else begin
                  ncnt--;
               end
            end
         end
         1: begin
            if (ncnt == 0) begin
               ack_rcv = 1'b1;
               phase   = 2;
            end else begin
               ncnt--;
            end
         end
         default: ;
      endcase
      if (pend.size() != 0 && (host_always || $urandom_range(0, 3) != 0)) begin
         wr_valid = 1'b1;
         wr_addr  = pend[0].addr;
         wr_data  = pend[0].data;
         if (wr_ready) begin
            push_pend = 1'b1;
            push_msg  = pend.pop_front();
         end
      end else begin
         wr_valid = 1'b0;
         wr_addr  = AW'($urandom);
         wr_data  = $urandom;
      end
   endtask

   task automatic run_engine(input int maxc);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         eng_step();
         if (pend.size() == 0 && mq.size() == 0 && !push_pend) begin
            ok = 1'b1;
            break;
         end
      end
      wr_valid = 1'b0;
      chk("engine_drain", 64'(ok), 1);
   endtask

   initial begin
      bit ok;
      int n, pulses, reqs, dn;
      bit seen;

      // Plans with hand-derived outcomes: fill/wrap with 6 messages, timeout-edge ack, exhaustion.
      tbl[0] = '{8'hA0, 32'hA0A0_0000, 0, 30, 1'b1, 1};
      tbl[1] = '{8'hA1, 32'hA1A1_0001, 1,  1, 1'b1, 2};
      tbl[2] = '{8'hA2, 32'hA2A2_0002, 4,  5, 1'b0, 4};
      tbl[3] = '{8'hA3, 32'hA3A3_0003, 0, 32, 1'b1, 1};
      tbl[4] = '{8'hA4, 32'hA4A4_0004, 3,  2, 1'b1, 4};
      tbl[5] = '{8'hA5, 32'hA5A5_0005, 0,  1, 1'b1, 1};

      do_reset();
      chk("rst_req_tx", 64'(req_tx), 0);
      chk("rst_tx_done", 64'(tx_done), 0);
      chk("rst_tx_fail", 64'(tx_fail), 0);
      chk("rst_count", 64'(count), 0);
      chk("rst_wr_ready", 64'(wr_ready), 1);

      // Single message: latency, handshake, ack after 20 cycles.
      push_one(8'hAB, 32'h1234_5678);
      chk("lat_count", 64'(count), 1);
      chk("lat_req_early", 64'(req_tx), 0);
      @(negedge clk);
      chk("lat_req", 64'(req_tx), 1);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      chk("req_fall", 64'(req_tx), 0);
      chk("single_addr", 64'(tx_addr), 64'hAB);
      chk("single_data", 64'(tx_data), 64'h1234_5678);
      repeat (19) @(negedge clk);
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_rcv = 1'b0;
      chk("single_done", 64'(tx_done), 1);
      chk("single_count", 64'(count), 0);
      @(negedge clk);
      chk("single_done_1cyc", 64'(tx_done), 0);
      chk("single_no_rereq", 64'(req_tx), 0);

      // Retry after exact timeout, then ack on the very edge the timer expires.
      push_one(8'h3C, 32'hCAFE_0001);
      wait_req(10, ok);
      chk("retry_req1", 64'(ok), 1);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      measure_retry(n, pulses);
      chk("timeout_gap", 64'(n), 64'(TIMEOUT + 1));
      chk("timeout_no_pulse", 64'(pulses), 0);
      chk("retry_head", 64'(tx_addr), 64'h3C);
      chk("retry_count", 64'(count), 1);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      repeat (TIMEOUT - 1) @(negedge clk);
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_rcv = 1'b0;
      chk("ack_at_timeout_done", 64'(tx_done), 1);
      chk("ack_at_timeout_nofail", 64'(tx_fail), 0);
      chk("ack_at_timeout_count", 64'(count), 0);

      // Exhaustion: never acknowledged, four requests then a fail pulse; next entry follows.
      wr_valid = 1'b1;
      wr_addr  = 8'h51;
      wr_data  = 32'h5151_5151;
      @(negedge clk);
      wr_addr  = 8'h52;
      wr_data  = 32'h5252_5252;
      @(negedge clk);
      wr_valid = 1'b0;
      reqs = 0;
      seen = 1'b0;
      dn   = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         ack_tx = 1'b0;
         if (tx_done) dn++;
         if (tx_fail) begin
            seen = 1'b1;
            break;
         end
         if (req_tx) begin
            reqs++;
            chk("exh_head", 64'(tx_addr), 64'h51);
            ack_tx = 1'b1;
         end
      end
      ack_tx = 1'b0;
      chk("exh_fail_seen", 64'(seen), 1);
      chk("exh_requests", 64'(reqs), 64'(MAX_RETRY + 1));
      chk("exh_no_done", 64'(dn), 0);
      chk("exh_count", 64'(count), 1);
      @(negedge clk);
      chk("exh_fail_1cyc", 64'(tx_fail), 0);
      wait_req(10, ok);
      chk("exh_next_req", 64'(ok), 1);
      chk("exh_next_addr", 64'(tx_addr), 64'h52);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx  = 1'b0;
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_rcv = 1'b0;
      chk("exh_next_done", 64'(tx_done), 1);

      // Stale ack held high across the request must not complete it.
      push_one(8'h77, 32'h7777_0000);
      wait_req(10, ok);
      chk("stale_req", 64'(ok), 1);
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      measure_retry(n, pulses);
      chk("stale_gap", 64'(n), 64'(TIMEOUT + 1));
      chk("stale_no_pulse", 64'(pulses), 0);
      ack_rcv = 1'b0;
      ack_tx  = 1'b1;
      @(negedge clk);
      ack_tx  = 1'b0;
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_rcv = 1'b0;
      chk("stale_then_done", 64'(tx_done), 1);

      // No request while ACK_TX is still high.
      ack_tx = 1'b1;
      push_one(8'h99, 32'h9999_0000);
      repeat (4) @(negedge clk);
      chk("ack_tx_blocks_req", 64'(req_tx), 0);
      ack_tx = 1'b0;
      @(negedge clk);
      chk("req_after_ack_tx_low", 64'(req_tx), 1);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx  = 1'b0;
      ack_rcv = 1'b1;
      @(negedge clk);
      ack_rcv = 1'b0;
      chk("blocked_msg_done", 64'(tx_done), 1);

      // Asynchronous reset in WAIT with three entries, then while requesting.
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = AW'(8'h11 + i);
         wr_data = DW'(i);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_req(10, ok);
      ack_tx = 1'b1;
      @(negedge clk);
      ack_tx = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_count", 64'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 64'(count), 0);
      chk("arst_wr_ready", 64'(wr_ready), 1);
      chk("arst_req", 64'(req_tx), 0);
      @(negedge clk);
      rst = 1'b0;
      push_one(8'h21, 32'h2121_0000);
      wait_req(10, ok);
      chk("arst2_req_before", 64'(ok), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst2_req_drop", 64'(req_tx), 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tx_done || tx_fail || req_tx) pulses++;
      end
      chk("post_rst_quiet", 64'(pulses), 0);

      // Table-driven plans pushed back-to-back: fills the queue and wraps the pointers.
      do_reset();
      eng_init();
      host_always = 1'b1;
      for (int i = 0; i < 6; i++) pend.push_back(tbl[i]);
      run_engine(4000);
      chk("tbl_pops", 64'(pops), 6);
      chk("tbl_fill", 64'(max_fill), 64'(DEPTH));

      // Random traffic with random retry counts and ack delays.
      eng_init();
      host_always = 1'b0;
      for (int i = 0; i < 40; i++)
         pend.push_back(mk(AW'($urandom), $urandom, int'($urandom_range(0, 4)),
                           int'($urandom_range(1, TIMEOUT))));
      run_engine(20000);
      chk("rand_pops", 64'(pops), 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
